muldiv_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 49 ++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Contents: operand width, funct3 operation encodings, the unit's FSM
// states, and the architectural boundary results for divide-by-zero and
// signed overflow.
package riscv_pkg;

   localparam int XLEN = 32;

   // funct3 encodings of the M extension
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   div_mode  0: shift-add multiply step, 1: restoring divide step
//   acc       multiply: {partial product high, remaining multiplier}
//             divide:   {partial remainder, remaining dividend / quotient}
//   operand   multiplicand magnitude (multiply) or divisor magnitude (divide)
//   bit_in    multiplier LSB (multiply) or next dividend bit (divide)
//   acc_next  accumulator after this iteration; for divide, bit 0 is left
//             clear for the caller to insert q_bit
//   q_bit     quotient bit produced by this divide step (0 for multiply)
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              div_mode,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   input  logic              bit_in,
   output logic [2*XLEN-1:0] acc_next,
   output logic              q_bit
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN-1:0] rem_new;

   always_comb begin
      sum       = '0;
      rem_shift = '0;
      rem_new   = '0;
      acc_next  = '0;
      q_bit     = 1'b0;
      if (div_mode) begin
         // Shift the next dividend bit into the remainder and try a subtract.
         // The partial remainder is always below the divisor, so the shifted
         // value fits in XLEN+1 bits and the restored result fits in XLEN.
         rem_shift = {acc[2*XLEN-1:XLEN], bit_in};
         q_bit     = (rem_shift >= {1'b0, operand});
         rem_new   = q_bit ? XLEN'(rem_shift - {1'b0, operand}) : rem_shift[XLEN-1:0];
         acc_next  = {rem_new, acc[XLEN-2:0], 1'b0};
      end else begin
         // Add the multiplicand into the high half when the multiplier LSB is
         // set, then shift the whole accumulator right by one; the carry
         // lands in the top bit.
         sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (bit_in ? {1'b0, operand} : '0);
         acc_next = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, kill         M-instruction present this cycle / abort in-flight op
//   op, op_a, op_b      funct3 and rs1/rs2 values
//   rd_in               destination register index
//   stall               hold PC/instruction this cycle
//   busy                FSM is not IDLE
//   wb_valid            one-cycle write-back pulse (RegWEn)
//   wb_rd, wb_data      write-back index and result (held after the pulse)
// Handshake: an instruction is accepted when start=1 and kill=0 in IDLE; the
// core holds it while stall=1 and retires it in the DONE cycle, where
// wb_valid=1 and stall=0. start outside IDLE is ignored; kill always wins.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            busy,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data
);

   import riscv_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

   muldiv_state_e     state;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   operand;
   muldiv_op_e        op_q;
   logic [4:0]        rd_q;
   logic              res_neg;

   // Decode of the incoming instruction
   muldiv_op_e      op_in;
   logic            a_signed, b_signed, sa, sb;
   logic            is_div_in, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, fast_res;

   always_comb begin
      op_in     = muldiv_op_e'(op);
      is_div_in = op[2];
      a_signed  = 1'b0;
      b_signed  = 1'b0;
      case (op_in)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default:   ;
      endcase
      sa       = a_signed & op_a[XLEN-1];
      sb       = b_signed & op_b[XLEN-1];
      mag_a    = sa ? -op_a : op_a;
      mag_b    = sb ? -op_b : op_b;
      div_zero = is_div_in & (op_b == '0);
      div_ovf  = is_div_in & ~op[0] & (op_a == INT_MIN) & (op_b == '1);
      // op[1] selects the remainder flavour of a divide
      if (div_zero) fast_res = op[1] ? op_a : DIV_ZERO_Q;
      else          fast_res = op[1] ? '0   : INT_MIN;
   end

   // Iteration datapath
   logic              div_q;
   logic              step_bit;
   logic [2*XLEN-1:0] step_acc;
   logic              q_bit;

   assign div_q    = op_q[2];
   assign step_bit = div_q ? acc[XLEN-1] : acc[0];

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode (div_q),
      .acc      (acc),
      .operand  (operand),
      .bit_in   (step_bit),
      .acc_next (step_acc),
      .q_bit    (q_bit)
   );

   // Result of the final iteration with sign fix-up applied
   logic [2*XLEN-1:0] acc_fin, prod;
   logic [XLEN-1:0]   div_val, run_res;

   always_comb begin
      acc_fin = step_acc | {{(2*XLEN-1){1'b0}}, q_bit};
      prod    = res_neg ? -acc_fin : acc_fin;
      div_val = op_q[1] ? acc_fin[2*XLEN-1:XLEN] : acc_fin[XLEN-1:0];
      if (div_q) run_res = res_neg ? -div_val : div_val;
      else       run_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // Reset gates stall so a held start cannot freeze the core during reset.
   assign stall = rst_n & (((state == IDLE) & start & ~kill) | (state == RUN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         operand  <= '0;
         op_q     <= OP_MUL;
         rd_q     <= '0;
         res_neg  <= 1'b0;
         busy     <= 1'b0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     op_q <= op_in;
                     rd_q <= rd_in;
                     cnt  <= '0;
                     busy <= 1'b1;
                     if (is_div_in) begin
                        acc     <= {{XLEN{1'b0}}, mag_a};
                        operand <= mag_b;
                        // remainder takes the dividend's sign
                        res_neg <= op[1] ? sa : (sa ^ sb);
                     end else begin
                        acc     <= {{XLEN{1'b0}}, mag_b};
                        operand <= mag_a;
                        res_neg <= sa ^ sb;
                     end
                     if (div_zero | div_ovf) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_in;
                        wb_data  <= fast_res;
                     end else begin
                        state <= RUN;
                     end
                  end
               end
               RUN: begin
                  acc <= acc_fin;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     state    <= DONE;
                     wb_valid <= 1'b1;
                     wb_rd    <= rd_q;
                     wb_data  <= run_res;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors, latency/stall/pulse
// checks, fast paths, kill/restart, reset mid-operation, operand stability.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        kill;
   logic [2:0]  op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        stall;
   logic        busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_vec;
   int n_err;

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .kill     (kill),
      .op       (op),
      .op_a     (op_a),
      .op_b     (op_b),
      .rd_in    (rd_in),
      .stall    (stall),
      .busy     (busy),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one instruction in the current cycle (caller is just after a
   // rising edge). Observes exp_lat+3 cycles, counting stall cycles and
   // wb_valid pulses. With churn set, start stays high through DONE and the
   // operands/rd change every cycle after acceptance.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat, input bit churn);
      int          lat;
      int          pulses;
      int          stalls;
      logic [31:0] got_data;
      logic [4:0]  got_rd;
      lat = -1; pulses = 0; stalls = 0; got_data = '0; got_rd = '0;
      start = 1'b1; op = o; op_a = a; op_b = b; rd_in = rd;
      for (int c = 0; c <= exp_lat + 2; c++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (wb_valid) begin
            pulses++;
            if (lat < 0) begin
               lat      = c;
               got_data = wb_data;
               got_rd   = {27'd0, wb_rd};
            end
         end
         @(posedge clk); #1;
         start = churn && (c < exp_lat);
         if (churn) begin
            op_a  = 32'hDEAD_BEEF ^ c;
            op_b  = 32'h0000_0003;
            rd_in = 5'd17;
         end
      end
      start = 1'b0;
      check($sformatf("%s latency", tag), lat, exp_lat);
      check($sformatf("%s pulses", tag), pulses, 1);
      check($sformatf("%s stall cycles", tag), stalls, exp_lat);
      check($sformatf("%s wb_rd", tag), {27'd0, got_rd}, {27'd0, rd});
      check($sformatf("%s wb_data", tag), got_data, exp_data);
      check($sformatf("%s wb_data hold", tag), wb_data, exp_data);
      check($sformatf("%s busy after", tag), {31'd0, busy}, 32'd0);
   endtask

   task automatic kill_restart();
      int pulses;
      pulses = 0;
      start = 1'b1; op = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd4;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (wb_valid) pulses++;
         if (c == 10) check("kill busy before", {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
         start = 1'b0;
         kill  = (c == 9);
      end
      #1;
      check("kill busy cycle 11", {31'd0, busy}, 32'd0);
      check("kill wb_valid cycle 11", {31'd0, wb_valid}, 32'd0);
      check("kill pulses", pulses, 0);
      do_op("restart DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 33, 1'b0);
   endtask

   task automatic reset_mid_op();
      int pulses;
      pulses = 0;
      start = 1'b1; op = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 18) check("rst busy before", {31'd0, busy}, 32'd1);
      end
      rst_n = 1'b0;
      start = 1'b1;
      #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst stall", {31'd0, stall}, 32'd0);
      check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (wb_valid) pulses++;
      end
      check("rst no write", pulses, 0);
      check("rst busy after", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0; start = 1'b0; kill = 1'b0;
      op = '0; op_a = '0; op_b = '0; rd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset stall", {31'd0, stall}, 32'd0);
      check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
      check("reset wb_rd", {27'd0, wb_rd}, 32'd0);
      check("reset wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // multiply
      do_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0);
      do_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33, 1'b0);
      do_op("MULHSU min*min",  3'b010, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'hC000_0000, 33, 1'b0);
      do_op("MULHU min*min",   3'b011, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33, 1'b0);
      do_op("MULHU -1*-1",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33, 1'b0);
      do_op("MUL -1*-1",       3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0001, 33, 1'b0);
      do_op("MUL rd0 3*4",     3'b000, 32'd3,          32'd4,         5'd0,  32'd12,        33, 1'b0);
      // divide
      do_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33, 1'b0);
      do_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33, 1'b0);
      do_op("DIV 7/-2",        3'b100, 32'd7,          32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33, 1'b0);
      do_op("REM 7/-2",        3'b110, 32'd7,          32'hFFFF_FFFE, 5'd13, 32'd1,         33, 1'b0);
      do_op("DIVU 100/7",      3'b101, 32'd100,        32'd7,         5'd14, 32'd14,        33, 1'b0);
      do_op("REMU 100/7",      3'b111, 32'd100,        32'd7,         5'd15, 32'd2,         33, 1'b0);
      // fast paths
      do_op("DIVU 5/0",        3'b101, 32'd5,          32'd0,         5'd20, 32'hFFFF_FFFF, 1,  1'b0);
      do_op("REM 5/0",         3'b110, 32'd5,          32'd0,         5'd21, 32'd5,         1,  1'b0);
      do_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1,  1'b0);
      do_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,         1,  1'b0);
      // operand stability with start held high
      do_op("stable DIVU 100/7", 3'b101, 32'd100,      32'd7,         5'd9,  32'd14,        33, 1'b1);

      kill_restart();
      reset_mid_op();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
